// File: rtl/bit_stuffer.sv
// Serial bit stuffer: inserts a 0 after every STUFF_LEN consecutive 1s and stalls
// upstream while the stuffed bit goes out. Counts stuffed bits per packet.
module bit_stuffer #(
  parameter int STUFF_LEN = 6,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inb,
  input  logic          recving,
  input  logic          pause_out,
  output logic          pause_in,
  output logic          outb,
  output logic          sending,
  output logic [CW-1:0] stuff_total,
  output logic          pkt_done,
  output logic [1:0]    dbg_state
);

  localparam int OW = $clog2(STUFF_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS  = 2'd1,
    S_STUFF = 2'd2
  } state_t;

  // Handshake: upstream bit moves when recving & ~pause_in; output bit moves
  // when sending & ~pause_out. Both are sampled on the same rising clock edge.
  state_t        r_state;
  logic [OW-1:0] r_ones;
  logic [CW-1:0] r_stuff_total;
  logic          r_pkt_done;

  logic          w_stuff;
  logic          w_take_in;
  logic          w_ones_hit;
  logic [OW-1:0] w_ones_next;
  logic          w_total_max;

  assign w_stuff     = (r_state == S_STUFF);
  assign w_take_in   = ~w_stuff & recving & ~pause_out;
  assign w_ones_next = inb ? (r_ones + OW'(1)) : '0;
  assign w_ones_hit  = inb & (r_ones == OW'(STUFF_LEN - 1));
  assign w_total_max = &r_stuff_total;

  // Data path is zero-latency; reset forces the outputs low immediately.
  always_comb begin
    sending  = 1'b0;
    outb     = 1'b0;
    pause_in = 1'b0;
    if (!rst) begin
      if (w_stuff) begin
        sending  = 1'b1;
        outb     = 1'b0;
        pause_in = 1'b1;
      end else begin
        sending  = recving;
        outb     = recving & inb;
        pause_in = (r_state == S_PASS) ? pause_out : (recving & pause_out);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ones        <= '0;
      r_stuff_total <= '0;
      r_pkt_done    <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ones <= '0;
          if (recving) begin
            r_stuff_total <= '0;
            r_state       <= S_PASS;
            if (w_take_in) r_ones <= w_ones_next;
          end
        end
        S_PASS: begin
          if (w_take_in) begin
            r_ones <= w_ones_next;
            if (w_ones_hit) r_state <= S_STUFF;
          end else if (!recving) begin
            r_ones     <= '0;
            r_state    <= S_IDLE;
            r_pkt_done <= 1'b1;
          end
        end
        S_STUFF: begin
          // A stuff pending at the packet tail is still sent before closing.
          if (!pause_out) begin
            r_ones <= '0;
            if (!w_total_max) r_stuff_total <= r_stuff_total + CW'(1);
            if (recving) begin
              r_state <= S_PASS;
            end else begin
              r_state    <= S_IDLE;
              r_pkt_done <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ones  <= '0;
        end
      endcase
    end
  end

  assign stuff_total = r_stuff_total;
  assign pkt_done    = r_pkt_done;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_bit_stuffer.sv
// Self-checking bench for bit_stuffer: directed packets, stall/reset cases,
// counter saturation on a narrow instance, and randomized packets vs a model.
module tb_bit_stuffer;

  localparam int L = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       inb, recving, pause_out;
  logic       pause_in, outb, sending, pkt_done;
  logic [7:0] stuff_total;
  logic [1:0] dbg_state;

  logic       inb_2, recving_2, pause_out_2;
  logic       pause_in_2, outb_2, sending_2, pkt_done_2;
  logic [1:0] stuff_total_2;
  logic [1:0] dbg_state_2;

  bit_stuffer #(.STUFF_LEN(L), .CW(8)) dut (
    .clk(clk), .rst(rst), .inb(inb), .recving(recving), .pause_out(pause_out),
    .pause_in(pause_in), .outb(outb), .sending(sending),
    .stuff_total(stuff_total), .pkt_done(pkt_done), .dbg_state(dbg_state)
  );

  bit_stuffer #(.STUFF_LEN(2), .CW(2)) dut_2 (
    .clk(clk), .rst(rst), .inb(inb_2), .recving(recving_2), .pause_out(pause_out_2),
    .pause_in(pause_in_2), .outb(outb_2), .sending(sending_2),
    .stuff_total(stuff_total_2), .pkt_done(pkt_done_2), .dbg_state(dbg_state_2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] exp_q[$];   // {is_stuffed_bit (pause_in), outb}
  bit         pkt_bits[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_bits(input int n, input bit v);
    for (int i = 0; i < n; i++) pkt_bits.push_back(v);
  endtask

  // Reference: a 0 follows every run of L ones, including at the packet tail.
  task automatic build_expected(output int n_stuff);
    int ones;
    ones    = 0;
    n_stuff = 0;
    foreach (pkt_bits[i]) begin
      exp_q.push_back({1'b0, pkt_bits[i]});
      ones = pkt_bits[i] ? ones + 1 : 0;
      if (ones == L) begin
        exp_q.push_back(2'b10);
        ones = 0;
        n_stuff++;
      end
    end
  endtask

  task automatic run_packet(input string tag, input int pause_pct);
    int exp_stuff, exp_len, idx, cyc, sent;
    bit done_seen;
    logic [1:0] e;
    idx = 0; cyc = 0; sent = 0; done_seen = 0;
    build_expected(exp_stuff);
    exp_len = exp_q.size();
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      pause_out = ($urandom_range(99) < pause_pct);
      if (idx < pkt_bits.size()) begin
        recving = 1'b1;
        inb     = pkt_bits[idx];
      end else begin
        recving = 1'b0;
        inb     = 1'($urandom_range(1));
      end
      #1;
      if (pkt_done) done_seen = 1;
      if (sending && !pause_out) begin
        sent++;
        if (exp_q.size() == 0) begin
          check({tag, " extra_bit"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          check({tag, " bit"}, {30'd0, pause_in, outb}, {30'd0, e});
        end
      end
      if (recving && !pause_in) idx++;
    end
    check({tag, " done_seen"}, {31'd0, done_seen}, 1);
    check({tag, " bits_left"}, exp_q.size(), 0);
    check({tag, " stuff_total"}, {24'd0, stuff_total}, exp_stuff);
    if (pause_pct == 0) check({tag, " out_cycles"}, sent, exp_len);
    @(negedge clk);
    pause_out = 1'b0;
    recving   = 1'b0;
    #1;
    check({tag, " pulse_once"}, {31'd0, pkt_done}, 0);
    check({tag, " idle_sending"}, {31'd0, sending}, 0);
    check({tag, " total_hold"}, {24'd0, stuff_total}, exp_stuff);
    exp_q.delete();
    pkt_bits.delete();
  endtask

  task automatic drive_ones(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      recving = 1'b1; inb = 1'b1; pause_out = 1'b0;
      #1;
      check(tag, {29'd0, sending, pause_in, outb}, 3'b101);
    end
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    bit seen;
    seen = 0; cyc = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      recving = 1'b0; pause_out = 1'b0;
      #1;
      cyc++;
      if (pkt_done) seen = 1;
    end
    check(tag, {31'd0, seen}, 1);
  endtask

  initial begin
    int idx, cyc, len;
    bit seen;
    rst = 1'b1; inb = 1'b0; recving = 1'b0; pause_out = 1'b0;
    inb_2 = 1'b0; recving_2 = 1'b0; pause_out_2 = 1'b0;
    #1;
    check("rst_outputs", {28'd0, sending, pause_in, outb, pkt_done}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_total", {24'd0, stuff_total}, 0);
    check("rst_state", {30'd0, dbg_state}, 0);

    add_bits(8, 1);                      run_packet("t1_ones8", 0);
    add_bits(6, 1);                      run_packet("t2_ones6", 0);
    add_bits(5, 1); add_bits(1, 0); add_bits(5, 1);
                                         run_packet("t3_no_stuff", 0);
    add_bits(12, 1);                     run_packet("t4_ones12", 0);

    // Downstream stall while a stuffed bit is pending.
    drive_ones(L, "t5_pass");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pause_out = 1'b1; recving = 1'b1; inb = 1'b1;
      #1;
      check("t5_stall_out", {29'd0, sending, pause_in, outb}, 3'b110);
      check("t5_stall_state", {30'd0, dbg_state}, 2);
      check("t5_stall_total", {24'd0, stuff_total}, 0);
    end
    @(negedge clk);
    pause_out = 1'b0;
    #1;
    check("t5_stuff_out", {29'd0, sending, pause_in, outb}, 3'b110);
    @(negedge clk);
    #1;
    check("t5_after", {29'd0, sending, pause_in, outb}, 3'b101);
    check("t5_total", {24'd0, stuff_total}, 1);
    wait_done("t5_done");

    // Reset in the middle of a stuff.
    drive_ones(L, "t6_pass");
    @(negedge clk);
    pause_out = 1'b1;
    #1;
    check("t6_in_stuff", {30'd0, dbg_state}, 2);
    rst = 1'b1;
    #1;
    check("t6_rst_out", {29'd0, sending, pause_in, outb}, 0);
    check("t6_rst_state", {30'd0, dbg_state}, 0);
    @(negedge clk);
    rst = 1'b0; recving = 1'b0; pause_out = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("t6_no_done", {31'd0, pkt_done}, 0);
    end
    check("t6_total_clr", {24'd0, stuff_total}, 0);
    add_bits(6, 1);                      run_packet("t6_next", 0);

    // Narrow counter: 8 ones with STUFF_LEN=2 gives 4 stuffs, saturating at 3.
    idx = 0; cyc = 0;
    while (idx < 8 && cyc < 100) begin
      @(negedge clk);
      recving_2 = 1'b1; inb_2 = 1'b1; pause_out_2 = 1'b0;
      #1;
      cyc++;
      if (!pause_in_2) idx++;
    end
    check("sat_accepted", idx, 8);
    seen = 0; cyc = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      recving_2 = 1'b0;
      #1;
      cyc++;
      if (pkt_done_2) seen = 1;
    end
    check("sat_done", {31'd0, seen}, 1);
    check("sat_total", {30'd0, stuff_total_2}, 3);

    // Randomized packets, biased toward long runs of ones, with random stalls.
    for (int p = 0; p < 25; p++) begin
      len = $urandom_range(40, 1);
      for (int i = 0; i < len; i++) pkt_bits.push_back($urandom_range(99) < 85);
      run_packet($sformatf("rand%0d", p), (p < 5) ? 0 : 35);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
